// File: rtl/pipelined_cla_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipelined_cla_adder_pkg                                      |
// | Description : Shared ALU definitions: lookahead group sizes, the ALU flag  |
// |               bundle used by result writeback, and the 4-way carry         |
// |               lookahead equations.                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pipelined_cla_adder_pkg;

  // Bits per first-level lookahead group.
  localparam int CLA_GROUP_W = 4;

  // Bits covered by one second-level super-group (four groups).
  localparam int CLA_SUPER_W = 16;

  // Flag bundle, ordered {negative, zero, overflow, c_out}; writeback reuses it.
  typedef struct packed {
    logic negative;
    logic zero;
    logic overflow;
    logic c_out;
  } alu_flags_t;

  // Number of 4-bit lookahead groups for a given operand width.
  function automatic int cla_num_groups(input int width);
    return width / CLA_GROUP_W;
  endfunction

  // Four-input carry lookahead. Bits [3:0] are the carries into positions 0..3
  // (bit 0 is the carry-in itself); bit 4 is the carry out of position 3.
  function automatic logic [4:0] cla4_carries(
    input logic [3:0] p,
    input logic [3:0] g,
    input logic       cin
  );
    logic [4:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_cla_adder_lcu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cla_lcu4                                                     |
// | Description : Four-group lookahead carry unit. Turns group P/G plus a      |
// |               carry-in into the carry entering each group, and reports the |
// |               combined P/G of all four groups for the next level up.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cla_lcu4
  import pipelined_cla_adder_pkg::*;
(
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [4:0] c,
  output logic       group_p,
  output logic       group_g
);

  // c[0] is the carry-in, c[4] is the carry out of the top group.
  assign c = cla4_carries(p, g, cin);

  // Combined terms are independent of cin, so levels can be chained without loops.
  assign group_p = &p;
  assign group_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_adder_pg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cla_pg_block4                                                |
// | Description : Per-bit propagate/generate and 4-bit group P/G terms.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cla_pg_block4
  import pipelined_cla_adder_pkg::*;
(
  input  logic [CLA_GROUP_W-1:0] a,
  input  logic [CLA_GROUP_W-1:0] b,
  output logic [CLA_GROUP_W-1:0] p,
  output logic [CLA_GROUP_W-1:0] g,
  output logic                   group_p,
  output logic                   group_g
);

  assign p = a ^ b;
  assign g = a & b;

  // Group propagates only if every bit propagates.
  assign group_p = &p;

  // Group generates if some bit generates and every bit above it propagates.
  assign group_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipelined_cla_adder                                          |
// | Description : Two-stage carry-lookahead adder/subtractor with valid/ready  |
// |               handshakes. Stage 1 registers P/G terms; stage 2 resolves    |
// |               carries with two-level lookahead and registers sum + flags.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NUM_GROUPS = cla_num_groups(WIDTH);
  localparam int NUM_SUPER  = WIDTH / CLA_SUPER_W;

  // Only 16 and 32 fit the two-level four-way lookahead tree.
  if (WIDTH != 16 && WIDTH != 32) begin : g_width_check
    $error("pipelined_cla_adder: WIDTH must be 16 or 32");
  end

  // ---------------------------------------------------------------- handshake
  logic s1_valid;
  logic s1_ready;
  logic s2_ready;
  logic s1_load;
  logic s2_load;

  assign s2_ready = !out_valid | out_ready;
  assign s1_ready = !s1_valid | s2_ready;
  assign in_ready = s1_ready;
  assign s1_load  = in_valid & s1_ready;
  assign s2_load  = s1_valid & s2_ready;

  // ------------------------------------------------------ stage 1: P/G terms
  logic [WIDTH-1:0]      b_eff;
  logic                  cin_eff;
  logic [WIDTH-1:0]      pg_p;
  logic [WIDTH-1:0]      pg_g;
  logic [NUM_GROUPS-1:0] pg_gp;
  logic [NUM_GROUPS-1:0] pg_gg;

  // Subtraction is a + ~b + 1, so the carry-in is forced and c_in ignored.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : c_in;

  for (genvar j = 0; j < NUM_GROUPS; j++) begin : g_pg
    cla_pg_block4 u_pg (
      .a       (a[CLA_GROUP_W*j +: CLA_GROUP_W]),
      .b       (b_eff[CLA_GROUP_W*j +: CLA_GROUP_W]),
      .p       (pg_p[CLA_GROUP_W*j +: CLA_GROUP_W]),
      .g       (pg_g[CLA_GROUP_W*j +: CLA_GROUP_W]),
      .group_p (pg_gp[j]),
      .group_g (pg_gg[j])
    );
  end

  logic [WIDTH-1:0]      s1_p;
  logic [WIDTH-1:0]      s1_g;
  logic [NUM_GROUPS-1:0] s1_gp;
  logic [NUM_GROUPS-1:0] s1_gg;
  logic                  s1_cin;
  logic                  s1_a_msb;
  logic                  s1_b_msb;

  // Stage 1 datapath register; contents are qualified by s1_valid so no reset.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_p     <= pg_p;
      s1_g     <= pg_g;
      s1_gp    <= pg_gp;
      s1_gg    <= pg_gg;
      s1_cin   <= cin_eff;
      s1_a_msb <= a[WIDTH-1];
      s1_b_msb <= b_eff[WIDTH-1];
    end
  end

  // Stage 1 occupancy: refills from upstream whenever it can move on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
    end
  end

  // ------------------------------------------ stage 2: carry resolution, sum
  logic [NUM_GROUPS-1:0] grp_cin;
  logic                  carry_top;

  if (WIDTH == 16) begin : g_one_level
    logic [4:0] lc;
    logic       top_p;
    logic       top_g;
    logic       unused_one_level;

    cla_lcu4 u_lcu (
      .p       (s1_gp),
      .g       (s1_gg),
      .cin     (s1_cin),
      .c       (lc),
      .group_p (top_p),
      .group_g (top_g)
    );

    assign grp_cin          = lc[3:0];
    assign carry_top        = lc[4];
    assign unused_one_level = top_p ^ top_g;
  end else begin : g_two_level
    logic [3:0]           sup_p;
    logic [3:0]           sup_g;
    logic [4:0]           sup_c;
    logic                 top_p;
    logic                 top_g;
    logic [NUM_SUPER-1:0] unused_super_cout;
    logic                 unused_two_level;

    // First level: each 16-bit super-group resolves its own four group carries.
    for (genvar s = 0; s < NUM_SUPER; s++) begin : g_super
      logic [4:0] lc;

      cla_lcu4 u_lcu (
        .p       (s1_gp[4*s +: 4]),
        .g       (s1_gg[4*s +: 4]),
        .cin     (sup_c[s]),
        .c       (lc),
        .group_p (sup_p[s]),
        .group_g (sup_g[s])
      );

      assign grp_cin[4*s +: 4] = lc[3:0];
      assign unused_super_cout[s] = lc[4];
    end

    // Unused lookahead slots neither propagate nor generate.
    for (genvar s = NUM_SUPER; s < 4; s++) begin : g_pad
      assign sup_p[s] = 1'b0;
      assign sup_g[s] = 1'b0;
    end

    // Second level: chains the super-groups from the stage carry-in.
    cla_lcu4 u_lcu_top (
      .p       (sup_p),
      .g       (sup_g),
      .cin     (s1_cin),
      .c       (sup_c),
      .group_p (top_p),
      .group_g (top_g)
    );

    assign carry_top        = sup_c[NUM_SUPER];
    assign unused_two_level = ^{top_p, top_g, sup_c[4:NUM_SUPER+1], unused_super_cout};
  end

  logic [WIDTH-1:0]      st2_sum;
  logic [NUM_GROUPS-1:0] unused_grp_cout;

  // Bit carries inside each group come from its group carry-in and local P/G.
  for (genvar j = 0; j < NUM_GROUPS; j++) begin : g_bits
    logic [4:0] bc;

    assign bc = cla4_carries(s1_p[CLA_GROUP_W*j +: CLA_GROUP_W],
                             s1_g[CLA_GROUP_W*j +: CLA_GROUP_W],
                             grp_cin[j]);
    assign st2_sum[CLA_GROUP_W*j +: CLA_GROUP_W] = s1_p[CLA_GROUP_W*j +: CLA_GROUP_W] ^ bc[3:0];
    assign unused_grp_cout[j] = bc[4];
  end

  alu_flags_t st2_flags;

  // Flags for the stage 2 result. Signed overflow uses the operand-sign form,
  // which equals carry[WIDTH] ^ carry[WIDTH-1] for a + b_eff + cin.
  always_comb begin
    st2_flags          = '0;
    st2_flags.c_out    = carry_top;
    st2_flags.overflow = (s1_a_msb ~^ s1_b_msb) & (s1_a_msb ^ st2_sum[WIDTH-1]);
    st2_flags.zero     = ~|st2_sum;
    st2_flags.negative = st2_sum[WIDTH-1];
  end

  // ----------------------------------------------------------- output stage
  alu_flags_t flags_q;

  // Output valid: advances when the consumer takes the result or it is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
    end
  end

  // Output result and flags; held while stalled so the consumer sees stable data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= '0;
      flags_q <= '0;
    end else if (s2_load) begin
      sum     <= st2_sum;
      flags_q <= st2_flags;
    end
  end

  assign c_out    = flags_q.c_out;
  assign overflow = flags_q.overflow;
  assign zero     = flags_q.zero;
  assign negative = flags_q.negative;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipelined_cla_adder                                       |
// | Description : Scoreboard bench for pipelined_cla_adder: driver pushes      |
// |               model results on accept, monitor pops on output transfer.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipelined_cla_adder;

  localparam int W = 32;
  localparam longint SMAX = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam longint SMIN = -(64'sd1 <<< (W - 1));

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;
  logic         zero;
  logic         negative;

  pipelined_cla_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         zero;
    logic         neg;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           checks = 0;
  int           failures = 0;
  bit           rand_ready = 1'b0;
  bit           held_valid = 1'b0;
  logic [W-1:0] held_sum;
  logic [3:0]   held_flags;

  // Reference: integer arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tc, input logic ts);
    exp_t            e;
    longint unsigned ua, ub, tot;
    longint          sa, sb, sr;
    ua = ta;
    ub = tb;
    sa = $signed(ta);
    sb = $signed(tb);
    if (ts) begin
      tot     = ua - ub;
      e.c_out = (ua >= ub);
      sr      = sa - sb;
    end else begin
      tot     = ua + ub + longint'(tc);
      e.c_out = tot[W];
      sr      = sa + sb + longint'(tc);
    end
    e.sum  = tot[W-1:0];
    e.ovf  = (sr > SMAX) || (sr < SMIN);
    e.zero = (e.sum == '0);
    e.neg  = e.sum[W-1];
    return e;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic tc, input logic ts, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    a = ta;
    b = tb_v;
    c_in = tc;
    sub = ts;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(model(ta, tb_v, tc, ts));
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
      if (!done && waits > 1000) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, required accept", waits);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    c_in = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_drain: pending=%0d required=0", name, sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops and compares on every output transfer, checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        checks++;
        if (sum !== held_sum || {negative, zero, overflow, c_out} !== held_flags) begin
          failures++;
          $display("FAIL stall_hold: sum=%h flags=%b required sum=%h flags=%b",
                   sum, {negative, zero, overflow, c_out}, held_sum, held_flags);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: sum=%h required no output", sum);
        end else begin
          mon_e = sb_q.pop_front();
          if (sum !== mon_e.sum || c_out !== mon_e.c_out || overflow !== mon_e.ovf ||
              zero !== mon_e.zero || negative !== mon_e.neg) begin
            failures++;
            $display("FAIL result: sum=%h c=%b v=%b z=%b n=%b required sum=%h c=%b v=%b z=%b n=%b",
                     sum, c_out, overflow, zero, negative,
                     mon_e.sum, mon_e.c_out, mon_e.ovf, mon_e.zero, mon_e.neg);
          end
        end
      end
      held_valid = out_valid && !out_ready;
      held_sum   = sum;
      held_flags = {negative, zero, overflow, c_out};
    end
  end

  // Random consumer back-pressure while enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int total_w;

    // Asynchronous reset state.
    #1 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", W'(out_valid), '0);
    chk("reset_sum", sum, '0);
    chk("reset_flags", W'({negative, zero, overflow, c_out}), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", W'(in_ready), W'(1));
    @(posedge clk);
    #1;

    // Directed corner cases (c_in is ignored for subtraction).
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, w);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, w);
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, w);
    send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, w);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, w);
    send(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, w);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, w);
    drain("directed");

    // Latency from an empty pipeline.
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, w);
    @(negedge clk);
    chk("latency_one_edge", W'(out_valid), '0);
    @(negedge clk);
    chk("latency_two_edges", W'(out_valid), W'(1));
    @(posedge clk);
    #1;
    drain("latency");

    // Back-to-back stream: never back-pressured.
    for (int i = 0; i < 8; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
      chk("b2b_in_ready_wait", W'(w), '0);
    end
    drain("b2b");

    // Same stream with a four-cycle consumer stall in the middle.
    total_w = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
          total_w += w;
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    chk("stall_in_ready_dropped", W'(total_w > 0), W'(1));
    drain("stall");

    // Reset with two results in flight.
    out_ready = 1'b0;
    send(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b0, w);
    send(32'h0000_0003, 32'h0000_0009, 1'b0, 1'b1, w);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", W'(out_valid), '0);
    chk("midreset_sum", sum, '0);
    chk("midreset_flags", W'({negative, zero, overflow, c_out}), '0);
    chk("midreset_in_ready", W'(in_ready), W'(1));
    sb_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_idle", W'(out_valid), '0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random back-pressure and input gaps.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain("random");

    chk("scoreboard_empty", W'(sb_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
